freq_meter: RTL and testbench
=============================

# freq_meter

Measures an incoming square-wave signal against the system clock: counts rising edges of `sig_in` over a fixed gate window of `GATE_CYCLES` clocks and measures the clock-cycle period between consecutive rising edges. It is the receiving end of the counter chain: it checks divided clocks such as the `/10`, `/100` and `/1000` outputs of the frequency divider, and it measures any external slow signal. Results are registered and qualified by one-cycle valid pulses.

## Interface
- `GATE_CYCLES`, default 1000: gate window length in `clk` cycles. Legal range is ≥2.
- `CNT_W`, default 16: width of the edge-count result.
- `PER_W`, default 16: width of the period result and period counter.
- `clk` input, 1 bit: system clock, rising-edge active.
- `rst` input, 1 bit: reset, asynchronous, active-low.
- `en` input, 1 bit: measurement enable, synchronous.
- `sig_in` input, 1 bit: measured signal, asynchronous to `clk`.
- `freq_cnt` output, `CNT_W` bits: rising edges counted in the last completed window.
- `freq_ovf` output, 1 bit: the last window's count saturated.
- `freq_valid` output, 1 bit: 1-cycle pulse; `freq_cnt` and `freq_ovf` updated.
- `period` output, `PER_W` bits: `clk` cycles between the last two rising edges.
- `period_valid` output, 1 bit: 1-cycle pulse; `period` updated.
- `timeout` output, 1 bit: no edge for 2^`PER_W`−1 cycles. Level signal.

## Operation
- **Reset values:** all outputs 0. Synchronizer, edge register, gate counter, edge counter and period counter are 0. `armed`=0. FSM is in IDLE.
- **Input path:**
  - 2-flop synchronizer `s1`→`s2`, then delay flop `s3`.
  - `edge` = `s2 & ~s3`, a 1-cycle pulse.
  - `sig_in` pulses shorter than 1 `clk` are not guaranteed to be seen.
- **FSM has two states.**
  - IDLE: `en`=0. Gate, edge and period counters are held at 0 and `armed`=0. Result outputs hold their last values. Valid pulses are 0 and `timeout` is 0.
  - IDLE → GATE when `en`=1. The first counted cycle is the cycle after the transition, with gate counter `g`=0.
  - GATE → IDLE when `en`=0, checked every cycle. A partial window is discarded with no `freq_valid`.
- **Gate (GATE state):**
  - `g` counts 0..`GATE_CYCLES`−1, then wraps to 0. Windows are back-to-back with no dead cycle.
  - Edge counter `ec` increments on `edge` and saturates at 2^`CNT_W`−1. Saturation sets the window's overflow flag `wo`.
  - In the cycle with `g`=`GATE_CYCLES`−1, the result includes that cycle's edge: `freq_cnt` ← sat(`ec`+`edge`) and `freq_ovf` ← `wo` | saturation-this-cycle.
  - In the same cycle, `ec` and `wo` clear to 0. `freq_valid`=1 on the next cycle, together with the new data.
- **Period (GATE state):**
  - Period counter `p` increments every cycle and saturates at 2^`PER_W`−1.
  - On `edge` with `armed`=1: `period` ← `p`+1 and `period_valid` pulses next cycle. Then `p` ← 0.
  - On `edge` with `armed`=0: `armed` ← 1 and `p` ← 0. No output.
  - Example: edges at cycles t and t+10 give `period`=10.
  - If `p` reaches 2^`PER_W`−1: `timeout` ← 1 and `armed` ← 0. The next edge only re-arms; it clears `timeout` and produces no `period_valid`.
- **Simultaneous events:** a window-end and an edge in the same cycle update both results. A window-end edge is counted in the closing window, not the next one.
- **Reset mid-operation** forces the reset values immediately. No valid pulse is generated on reset release.

## Timing
- `sig_in` rise → `edge` pulse: 2–3 `clk` cycles, depending on sampling phase.
- Window close → `freq_valid`: 1 cycle, registered.
- First `freq_valid` arrives `GATE_CYCLES`+1 cycles after the IDLE→GATE transition. After that, one pulse every `GATE_CYCLES` cycles exactly.
- Qualifying `edge` → `period_valid`: 1 cycle.
- All outputs are registered. There are no combinational input-to-output paths.

## Structure
- Shared package `counter_pkg`:
  - FSM state enum `fm_state_t` {IDLE, GATE}.
  - Saturating-increment function `sat_inc`.
  - Constant `FM_SYNC_STAGES`=2.
- One sub-module: `edge_sync`, holding the synchronizer, `s3` and the rising-edge pulse output. It is reusable by other blocks that take external inputs.
- Gate counter, period logic and output registers live in `freq_meter`.

## Test plan
- **/10 input:** `sig_in` = `clk`/10 square wave (5 high, 5 low), `GATE_CYCLES`=1000, `en`=1 → every `freq_valid` gives `freq_cnt`=100 and `freq_ovf`=0. Every qualifying edge gives `period`=10.
- **/1000 input:** `sig_in` = `clk`/1000, `GATE_CYCLES`=100 → each `freq_cnt` is 0 or 1. `period`=1000, with no `timeout` at `PER_W`=16.
- **Timeout:** `PER_W`=4, `sig_in` held low after two edges → `timeout`=1 exactly 15 cycles after the last `edge`. The next edge clears `timeout` without `period_valid`. The edge after that gives `period_valid`.
- **Overflow:** `CNT_W`=3, `GATE_CYCLES`=100, `sig_in` = `clk`/4 → `freq_cnt`=7 and `freq_ovf`=1. After `sig_in` slows to `clk`/50, the next full window shows `freq_ovf`=0.
- **Window-end edge:** place an `edge` exactly at `g`=`GATE_CYCLES`−1 → it is counted in the closing window, and the next window starts with `ec`=0.
- **`en` drop and reset:**
  - Drop `en` mid-window → no `freq_valid`; outputs hold their values.
  - Re-enable → first `freq_valid` after `GATE_CYCLES`+1 cycles.
  - Assert `rst` low mid-window → all outputs 0 immediately.

Source files
------------

// File: rtl/counter_pkg.sv
// counter_pkg: shared types, constants and helpers for the counter chain.
//   fm_state_t     - freq_meter FSM state encoding (IDLE, GATE)
//   FM_SYNC_STAGES - depth of the input synchronizer ahead of the edge flop
//   sat_inc        - saturating increment on values up to 32 bits wide
package counter_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        GATE = 1'b1
    } fm_state_t;

    localparam int unsigned FM_SYNC_STAGES = 2;

    // Callers zero-extend to 32 bits and truncate the result back to their width.
    function automatic logic [31:0] sat_inc(input logic [31:0] v, input logic [31:0] max);
        return (v >= max) ? max : v + 32'd1;
    endfunction

endpackage

// File: rtl/freq_meter_if.sv
// freq_meter_if: measurement control and result bundle of freq_meter.
//   en, sig_in             - enable and measured signal (master -> slave)
//   freq_cnt/ovf/valid     - gate-window edge count result (slave -> master)
//   period/period_valid    - edge-to-edge period result (slave -> master)
//   timeout                - no edge seen within the period counter range
interface freq_meter_if #(
    parameter int CNT_W = 16,
    parameter int PER_W = 16
);
    logic             en;
    logic             sig_in;
    logic [CNT_W-1:0] freq_cnt;
    logic             freq_ovf;
    logic             freq_valid;
    logic [PER_W-1:0] period;
    logic             period_valid;
    logic             timeout;

    modport master (
        output en, sig_in,
        input  freq_cnt, freq_ovf, freq_valid, period, period_valid, timeout
    );

    modport slave (
        input  en, sig_in,
        output freq_cnt, freq_ovf, freq_valid, period, period_valid, timeout
    );
endinterface

// File: rtl/freq_meter_edge_sync.sv
// edge_sync: brings an asynchronous input into the clk domain and flags its
// rising edges.
//   clk   - system clock, rising edge
//   rst   - asynchronous reset, active low
//   din   - asynchronous input
//   pulse - one-cycle pulse, 2-3 cycles after a rising edge of din
module edge_sync
    import counter_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic din,
    output logic pulse
);

    logic [FM_SYNC_STAGES-1:0] sync;
    logic                      dly;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync <= '0;
            dly  <= 1'b0;
        end else begin
            sync <= {sync[FM_SYNC_STAGES-2:0], din};
            dly  <= sync[FM_SYNC_STAGES-1];
        end
    end

    assign pulse = sync[FM_SYNC_STAGES-1] & ~dly;

endmodule

// File: rtl/freq_meter.sv
// freq_meter: counts rising edges of sig_in over back-to-back windows of
// GATE_CYCLES clocks and measures the clk-cycle period between edges.
//   clk, rst            - system clock; asynchronous active-low reset
//   bus.en              - measurement enable (IDLE when low)
//   bus.sig_in          - measured signal, asynchronous to clk
//   bus.freq_cnt/ovf    - edges in the last full window / saturation flag
//   bus.freq_valid      - one-cycle pulse when freq_cnt/freq_ovf update
//   bus.period          - clk cycles between the last two rising edges
//   bus.period_valid    - one-cycle pulse when period updates
//   bus.timeout         - no edge for 2^PER_W-1 cycles (level)
module freq_meter
    import counter_pkg::*;
#(
    parameter int GATE_CYCLES = 1000,
    parameter int CNT_W       = 16,
    parameter int PER_W       = 16
) (
    input logic         clk,
    input logic         rst,
    freq_meter_if.slave bus
);

    localparam int unsigned      G_W      = (GATE_CYCLES > 2) ? $clog2(GATE_CYCLES) : 1;
    localparam logic [G_W-1:0]   G_LAST   = G_W'(GATE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;
    localparam logic [PER_W-1:0] PER_MAX  = '1;

    fm_state_t        state, state_n;
    logic             run, win_end;
    logic             edge_p;

    logic [G_W-1:0]   g;
    logic [CNT_W-1:0] ec, ec_inc;
    logic             wo, ec_sat;
    logic [PER_W-1:0] p, p_inc;
    logic             armed;

    logic [CNT_W-1:0] freq_cnt_q;
    logic             freq_ovf_q, freq_valid_q;
    logic [PER_W-1:0] period_q;
    logic             period_valid_q, timeout_q;

    edge_sync u_sync (
        .clk   (clk),
        .rst   (rst),
        .din   (bus.sig_in),
        .pulse (edge_p)
    );

    // FSM: state register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= state_n;
    end

    // FSM: next state
    always_comb begin
        state_n = state;
        case (state)
            IDLE: if (bus.en)  state_n = GATE;
            GATE: if (!bus.en) state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    // FSM: control outputs
    always_comb begin
        run     = (state == GATE);
        win_end = run && (g == G_LAST);
    end

    // The closing cycle's edge belongs to the closing window, so the
    // published count and overflow use the already-incremented values.
    assign ec_sat = edge_p && (ec == CNT_MAX);
    assign ec_inc = edge_p ? CNT_W'(sat_inc(32'(ec), 32'(CNT_MAX))) : ec;
    assign p_inc  = PER_W'(sat_inc(32'(p), 32'(PER_MAX)));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            g              <= '0;
            ec             <= '0;
            wo             <= 1'b0;
            p              <= '0;
            armed          <= 1'b0;
            freq_cnt_q     <= '0;
            freq_ovf_q     <= 1'b0;
            freq_valid_q   <= 1'b0;
            period_q       <= '0;
            period_valid_q <= 1'b0;
            timeout_q      <= 1'b0;
        end else begin
            freq_valid_q   <= 1'b0;
            period_valid_q <= 1'b0;
            if (!run) begin
                g         <= '0;
                ec        <= '0;
                wo        <= 1'b0;
                p         <= '0;
                armed     <= 1'b0;
                timeout_q <= 1'b0;
            end else begin
                if (win_end) begin
                    g            <= '0;
                    ec           <= '0;
                    wo           <= 1'b0;
                    freq_cnt_q   <= ec_inc;
                    freq_ovf_q   <= wo | ec_sat;
                    freq_valid_q <= 1'b1;
                end else begin
                    g  <= g + 1'b1;
                    ec <= ec_inc;
                    wo <= wo | ec_sat;
                end

                // While armed, p never exceeds PER_MAX-1 at an edge, so p+1 fits.
                if (edge_p) begin
                    p <= '0;
                    if (armed) begin
                        period_q       <= p + 1'b1;
                        period_valid_q <= 1'b1;
                    end else begin
                        armed     <= 1'b1;
                        timeout_q <= 1'b0;
                    end
                end else begin
                    p <= p_inc;
                    if (p_inc == PER_MAX) begin
                        timeout_q <= 1'b1;
                        armed     <= 1'b0;
                    end
                end
            end
        end
    end

    assign bus.freq_cnt     = freq_cnt_q;
    assign bus.freq_ovf     = freq_ovf_q;
    assign bus.freq_valid   = freq_valid_q;
    assign bus.period       = period_q;
    assign bus.period_valid = period_valid_q;
    assign bus.timeout      = timeout_q;

endmodule

// File: tb/tb_freq_meter.sv
// tb_freq_meter: scoreboard bench for freq_meter.
//   u1: GATE_CYCLES=1000, CNT_W=16, PER_W=16  (/10 input, en drop, reset)
//   u2: GATE_CYCLES=100,  CNT_W=16, PER_W=16  (/1000 input, window-end edge)
//   u3: GATE_CYCLES=100,  CNT_W=3,  PER_W=4   (timeout, overflow)
// Inputs change 1 time unit after a rising clk edge; monitors sample on the
// falling edge. Expected results are queued before each stimulus sequence.
module tb_freq_meter;

    typedef struct packed {
        logic [15:0] cnt;
        logic        ovf;
    } fexp_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic sig = 1'b0;
    logic en1 = 1'b0, en2 = 1'b0, en3 = 1'b0;

    int n_cmp  = 0;
    int n_fail = 0;

    fexp_t fq[3][$];
    int    pq[3][$];

    always #5 clk = ~clk;

    freq_meter_if #(.CNT_W(16), .PER_W(16)) if1 ();
    freq_meter_if #(.CNT_W(16), .PER_W(16)) if2 ();
    freq_meter_if #(.CNT_W(3),  .PER_W(4))  if3 ();

    assign if1.en = en1;  assign if1.sig_in = sig;
    assign if2.en = en2;  assign if2.sig_in = sig;
    assign if3.en = en3;  assign if3.sig_in = sig;

    freq_meter #(.GATE_CYCLES(1000), .CNT_W(16), .PER_W(16)) u1 (.clk(clk), .rst(rst), .bus(if1));
    freq_meter #(.GATE_CYCLES(100),  .CNT_W(16), .PER_W(16)) u2 (.clk(clk), .rst(rst), .bus(if2));
    freq_meter #(.GATE_CYCLES(100),  .CNT_W(3),  .PER_W(4))  u3 (.clk(clk), .rst(rst), .bus(if3));

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, want %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic pushf(input int u, input int cnt, input bit ovf);
        fexp_t e;
        e.cnt = 16'(cnt);
        e.ovf = ovf;
        fq[u].push_back(e);
    endtask

    task automatic pushp(input int u, input int per);
        pq[u].push_back(per);
    endtask

    task automatic mon_f(input int u, input int cnt, input bit ovf);
        fexp_t e;
        chk($sformatf("u%0d freq_valid expected", u + 1), int'(fq[u].size() > 0), 1);
        if (fq[u].size() > 0) begin
            e = fq[u].pop_front();
            chk($sformatf("u%0d freq_cnt", u + 1), cnt, int'(e.cnt));
            chk($sformatf("u%0d freq_ovf", u + 1), int'(ovf), int'(e.ovf));
        end
    endtask

    task automatic mon_p(input int u, input int per);
        int e;
        chk($sformatf("u%0d period_valid expected", u + 1), int'(pq[u].size() > 0), 1);
        if (pq[u].size() > 0) begin
            e = pq[u].pop_front();
            chk($sformatf("u%0d period", u + 1), per, e);
        end
    endtask

    // Monitor: every valid pulse is matched against the head of its queue.
    always @(negedge clk) begin
        if (if1.freq_valid)   mon_f(0, int'(if1.freq_cnt), if1.freq_ovf);
        if (if2.freq_valid)   mon_f(1, int'(if2.freq_cnt), if2.freq_ovf);
        if (if3.freq_valid)   mon_f(2, int'(if3.freq_cnt), if3.freq_ovf);
        if (if1.period_valid) mon_p(0, int'(if1.period));
        if (if2.period_valid) mon_p(1, int'(if2.period));
        if (if3.period_valid) mon_p(2, int'(if3.period));
    end

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic sq(input int half, input int nper);
        repeat (nper) begin
            sig = 1'b1; cyc(half);
            sig = 1'b0; cyc(half);
        end
    endtask

    task automatic do_reset();
        @(negedge clk) rst = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        cyc(1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        bit got;

        // Reset values
        #2;
        chk("u1 reset freq_cnt", int'(if1.freq_cnt), 0);
        chk("u1 reset period", int'(if1.period), 0);
        chk("u3 reset timeout", int'(if3.timeout), 0);
        do_reset();

        // u1: /10 input, three full windows of 100 edges, period 10
        repeat (3)   pushf(0, 100, 1'b0);
        repeat (299) pushp(0, 10);
        en1 = 1'b1;
        sq(5, 300);
        cyc(5);
        en1 = 1'b0;
        cyc(5);

        // u1: en dropped mid-window, results hold
        repeat (49) pushp(0, 10);
        en1 = 1'b1;
        sq(5, 50);
        en1 = 1'b0;
        cyc(3);
        chk("u1 hold freq_cnt", int'(if1.freq_cnt), 100);
        chk("u1 hold freq_ovf", int'(if1.freq_ovf), 0);
        chk("u1 hold period", int'(if1.period), 10);

        // u1: reset mid-window clears outputs immediately
        repeat (29) pushp(0, 10);
        en1 = 1'b1;
        sq(5, 30);
        cyc(2);
        @(negedge clk) rst = 1'b0;
        #1;
        chk("u1 rst freq_cnt", int'(if1.freq_cnt), 0);
        chk("u1 rst freq_ovf", int'(if1.freq_ovf), 0);
        chk("u1 rst period", int'(if1.period), 0);
        chk("u1 rst timeout", int'(if1.timeout), 0);
        chk("u1 rst freq_valid", int'(if1.freq_valid), 0);
        chk("u1 rst period_valid", int'(if1.period_valid), 0);
        en1 = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        cyc(1);

        // u1: re-enable, first freq_valid GATE_CYCLES+1 clocks later
        pushf(0, 0, 1'b0);
        en1 = 1'b1;
        n   = 0;
        got = 1'b0;
        while (!got && n < 1100) begin
            @(posedge clk);
            n++;
            @(negedge clk);
            if (if1.freq_valid) got = 1'b1;
        end
        en1 = 1'b0;
        chk("u1 first freq_valid latency", n, 1001);
        cyc(3);

        // u2: /1000 input, windows of 100 hold 0 or 1 edge
        do_reset();
        for (int j = 0; j < 30; j++) pushf(1, (j % 10 == 0) ? 1 : 0, 1'b0);
        repeat (2) pushp(1, 1000);
        en2 = 1'b1;
        sq(500, 3);
        cyc(2);
        chk("u2 no timeout", int'(if2.timeout), 0);
        en2 = 1'b0;
        cyc(3);

        // u2: edge at g=GATE_CYCLES-1 closes window 0, next edge in window 1
        do_reset();
        pushf(1, 1, 1'b0);
        pushf(1, 1, 1'b0);
        pushp(1, 2);
        en2 = 1'b1;
        cyc(98);
        sig = 1'b1; cyc(1);
        sig = 1'b0; cyc(1);
        sig = 1'b1; cyc(3);
        sig = 1'b0; cyc(105);
        en2 = 1'b0;
        cyc(3);

        // u3: timeout exactly 15 cycles after the last edge
        do_reset();
        pushp(2, 5);
        pushp(2, 7);
        en3 = 1'b1;
        sig = 1'b1; cyc(2);
        sig = 1'b0; cyc(3);
        sig = 1'b1; cyc(2);
        sig = 1'b0; cyc(15);
        chk("u3 timeout at 14", int'(if3.timeout), 0);
        cyc(1);
        chk("u3 timeout at 15", int'(if3.timeout), 1);
        cyc(7);
        sig = 1'b1; cyc(2);
        sig = 1'b0;
        chk("u3 timeout before re-arm", int'(if3.timeout), 1);
        cyc(1);
        chk("u3 timeout cleared by edge", int'(if3.timeout), 0);
        cyc(4);
        sig = 1'b1; cyc(2);
        sig = 1'b0; cyc(5);
        en3 = 1'b0;
        cyc(3);

        // u3: /4 saturates a 3-bit count, then /50 windows recover
        do_reset();
        repeat (2)  pushf(2, 7, 1'b1);
        repeat (2)  pushf(2, 2, 1'b0);
        repeat (50) pushp(2, 4);
        en3 = 1'b1;
        sq(2, 50);
        sq(25, 4);
        cyc(3);
        chk("u3 timeout in /50", int'(if3.timeout), 1);
        en3 = 1'b0;
        cyc(5);

        for (int u = 0; u < 3; u++) begin
            chk($sformatf("u%0d freq results missing", u + 1), fq[u].size(), 0);
            chk($sformatf("u%0d period results missing", u + 1), pq[u].size(), 0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
